// File: rtl/vx_commit_arb.sv
// Commit arbiter: round-robin merge of execute-unit result packets into one registered writeback stream.
// Optional stall counters per unit are enabled by defining COMMIT_ARB_PERF_EN.
module vx_commit_arb #(
    parameter int NUM_UNITS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int UUID_W      = 44,
    localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int PKT_W      = UUID_W + NW_BITS + XLEN + NUM_THREADS + 1 + NR_BITS
                                + NUM_THREADS * XLEN + 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_UNITS-1:0]         in_valid,
    output logic [NUM_UNITS-1:0]         in_ready,
    input  logic [NUM_UNITS*PKT_W-1:0]   in_data,
    output logic                         wb_valid,
    output logic [UUID_W-1:0]            wb_uuid,
    output logic [NW_BITS-1:0]           wb_wid,
    output logic [XLEN-1:0]              wb_PC,
    output logic [NUM_THREADS-1:0]       wb_tmask,
    output logic [NR_BITS-1:0]           wb_rd,
    output logic [NUM_THREADS*XLEN-1:0]  wb_data,
    output logic                         wb_eop,
    output logic                         commit_valid,
    output logic [NW_BITS-1:0]           commit_wid,
`ifdef COMMIT_ARB_PERF_EN
    output logic [NUM_UNITS*44-1:0]      perf_stalls,
`endif
    output logic [63:0]                  instret
);

    localparam int UI_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int DATA_W  = NUM_THREADS * XLEN;
    localparam int EOP_O   = 0;
    localparam int SOP_O   = 1;
    localparam int DATA_O  = 2;
    localparam int RD_O    = DATA_O + DATA_W;
    localparam int WB_O    = RD_O + NR_BITS;
    localparam int TMASK_O = WB_O + 1;
    localparam int PC_O    = TMASK_O + NUM_THREADS;
    localparam int WID_O   = PC_O + XLEN;
    localparam int UUID_O  = WID_O + NW_BITS;

    function automatic logic [UI_W-1:0] rr_index(input logic [UI_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_UNITS) sum = sum - NUM_UNITS;
        return UI_W'(sum);
    endfunction

    logic                 locked;
    logic [UI_W-1:0]      lock_idx;
    logic [UI_W-1:0]      rr_ptr;

    // Stage p0: grant selection and packet field extraction
    logic [UI_W-1:0]      grant_idx_p0;
    logic                 vld_p0;
    logic [PKT_W-1:0]     pkt_p0;
    logic [UUID_W-1:0]    uuid_p0;
    logic [NW_BITS-1:0]   wid_p0;
    logic [XLEN-1:0]      pc_p0;
    logic [NUM_THREADS-1:0] tmask_p0;
    logic                 wb_p0;
    logic [NR_BITS-1:0]   rd_p0;
    logic [DATA_W-1:0]    data_p0;
    logic                 sop_p0;
    logic                 eop_p0;

    always_comb begin
        grant_idx_p0 = lock_idx;
        vld_p0       = 1'b0;
        if (locked) begin
            vld_p0 = in_valid[lock_idx];
        end else begin
            // Walk backwards so the unit nearest rr_ptr wins the last assignment.
            for (int i = NUM_UNITS - 1; i >= 0; i--) begin
                if (in_valid[rr_index(rr_ptr, i)]) begin
                    grant_idx_p0 = rr_index(rr_ptr, i);
                    vld_p0       = 1'b1;
                end
            end
        end
    end

    assign in_ready = vld_p0 ? (NUM_UNITS'(1) << grant_idx_p0) : '0;
    assign pkt_p0   = in_data[int'(grant_idx_p0) * PKT_W +: PKT_W];
    assign uuid_p0  = pkt_p0[UUID_O +: UUID_W];
    assign wid_p0   = pkt_p0[WID_O +: NW_BITS];
    assign pc_p0    = pkt_p0[PC_O +: XLEN];
    assign tmask_p0 = pkt_p0[TMASK_O +: NUM_THREADS];
    assign wb_p0    = pkt_p0[WB_O];
    assign rd_p0    = pkt_p0[RD_O +: NR_BITS];
    assign data_p0  = pkt_p0[DATA_O +: DATA_W];
    assign sop_p0   = pkt_p0[SOP_O];
    assign eop_p0   = pkt_p0[EOP_O];

    // Stage p1: registered writeback / commit outputs
    logic                   wb_vld_p1;
    logic                   commit_vld_p1;
    logic [NW_BITS-1:0]     commit_wid_p1;
    logic [63:0]            instret_p1;
    logic [UUID_W-1:0]      uuid_p1;
    logic [NW_BITS-1:0]     wid_p1;
    logic [XLEN-1:0]        pc_p1;
    logic [NUM_THREADS-1:0] tmask_p1;
    logic [NR_BITS-1:0]     rd_p1;
    logic [DATA_W-1:0]      data_p1;
    logic                   eop_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            locked        <= 1'b0;
            lock_idx      <= '0;
            rr_ptr        <= '0;
            wb_vld_p1     <= 1'b0;
            commit_vld_p1 <= 1'b0;
            commit_wid_p1 <= '0;
            instret_p1    <= '0;
            uuid_p1       <= '0;
            wid_p1        <= '0;
            pc_p1         <= '0;
            tmask_p1      <= '0;
            rd_p1         <= '0;
            data_p1       <= '0;
            eop_p1        <= 1'b0;
        end else begin
            wb_vld_p1     <= vld_p0 & wb_p0;
            commit_vld_p1 <= vld_p0 & eop_p0;
            if (vld_p0) begin
                uuid_p1  <= uuid_p0;
                wid_p1   <= wid_p0;
                pc_p1    <= pc_p0;
                tmask_p1 <= tmask_p0;
                rd_p1    <= rd_p0;
                data_p1  <= data_p0;
                eop_p1   <= eop_p0;
                if (eop_p0) begin
                    locked        <= 1'b0;
                    rr_ptr        <= rr_index(grant_idx_p0, 1);
                    commit_wid_p1 <= wid_p0;
                    instret_p1    <= instret_p1 + 64'd1;
                end else begin
                    locked   <= 1'b1;
                    lock_idx <= grant_idx_p0;
                end
            end
        end
    end

    assign wb_valid     = wb_vld_p1;
    assign wb_uuid      = uuid_p1;
    assign wb_wid       = wid_p1;
    assign wb_PC        = pc_p1;
    assign wb_tmask     = tmask_p1;
    assign wb_rd        = rd_p1;
    assign wb_data      = data_p1;
    assign wb_eop       = eop_p1;
    assign commit_valid = commit_vld_p1;
    assign commit_wid   = commit_wid_p1;
    assign instret      = instret_p1;

`ifdef COMMIT_ARB_PERF_EN
    function automatic logic [43:0] sat_inc(input logic [43:0] cnt);
        return (&cnt) ? cnt : cnt + 44'd1;
    endfunction

    logic [43:0] stall_cnt [NUM_UNITS];

    always_ff @(posedge clk) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (reset) begin
                stall_cnt[u] <= '0;
            end else if (in_valid[u] && !in_ready[u]) begin
                stall_cnt[u] <= sat_inc(stall_cnt[u]);
            end
        end
    end

    always_comb begin
        perf_stalls = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            perf_stalls[u*44 +: 44] = stall_cnt[u];
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && vld_p0) begin
            assert (tmask_p0 != '0) else $error("commit_arb: fired packet has empty tmask");
            if (locked) begin
                assert (!sop_p0) else $error("commit_arb: sop set on locked grant");
            end else begin
                assert (sop_p0) else $error("commit_arb: sop clear on unlocked grant");
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed bench for vx_commit_arb: single source, contention, lock, wb=0, reset-while-locked, optional stall counters.
module tb_vx_commit_arb;

    localparam int NU    = 4;
    localparam int NT    = 4;
    localparam int XL    = 32;
    localparam int NRB   = 6;
    localparam int UW    = 44;
    localparam int NWB   = 2;
    localparam int PKT_W = UW + NWB + XL + NT + 1 + NRB + NT*XL + 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NU-1:0]        in_valid;
    logic [NU-1:0]        in_ready;
    logic [NU*PKT_W-1:0]  in_data;
    logic                 wb_valid;
    logic [UW-1:0]        wb_uuid;
    logic [NWB-1:0]       wb_wid;
    logic [XL-1:0]        wb_PC;
    logic [NT-1:0]        wb_tmask;
    logic [NRB-1:0]       wb_rd;
    logic [NT*XL-1:0]     wb_data;
    logic                 wb_eop;
    logic                 commit_valid;
    logic [NWB-1:0]       commit_wid;
    logic [63:0]          instret;
`ifdef COMMIT_ARB_PERF_EN
    logic [NU*44-1:0]     perf_stalls;
`endif

    int errors = 0;
    int checks = 0;
    int commits;

    vx_commit_arb dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .wb_valid     (wb_valid),
        .wb_uuid      (wb_uuid),
        .wb_wid       (wb_wid),
        .wb_PC        (wb_PC),
        .wb_tmask     (wb_tmask),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_eop       (wb_eop),
        .commit_valid (commit_valid),
        .commit_wid   (commit_wid),
`ifdef COMMIT_ARB_PERF_EN
        .perf_stalls  (perf_stalls),
`endif
        .instret      (instret)
    );

    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] pack(input logic [UW-1:0] uuid, input logic [NWB-1:0] wid,
                                              input logic [XL-1:0] pc, input logic [NT-1:0] tmask,
                                              input logic wb, input logic [NRB-1:0] rd,
                                              input logic [NT*XL-1:0] data, input logic sop,
                                              input logic eop);
        return {uuid, wid, pc, tmask, wb, rd, data, sop, eop};
    endfunction

    task automatic put(input int u, input logic [PKT_W-1:0] pkt);
        in_data[u*PKT_W +: PKT_W] = pkt;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        in_data  = '0;
        repeat (2) step();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_commit", commit_valid, 0);
        check("rst_instret", instret, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        reset = 1'b0;

        // Single source on unit 2
        put(2, pack(44'h123_4567_89AB, 2'd1, 32'h0000_1000, 4'hF, 1'b1, 6'd5,
                    128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003, 1'b1, 1'b1));
        in_valid = 4'b0100;
        #1;
        check("single_ready", in_ready, 4'b0100);
        step();
        in_valid = '0;
        check("single_wb_valid", wb_valid, 1);
        check("single_wb_rd", wb_rd, 5);
        check("single_wb_wid", wb_wid, 1);
        check("single_wb_uuid", wb_uuid, 44'h123_4567_89AB);
        check("single_wb_pc", wb_PC, 32'h0000_1000);
        check("single_wb_tmask", wb_tmask, 4'hF);
        check("single_wb_data", wb_data, 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003);
        check("single_commit", commit_valid, 1);
        check("single_commit_wid", commit_wid, 1);
        check("single_instret", instret, 1);
        step();
        check("idle_wb_valid", wb_valid, 0);
        check("idle_commit", commit_valid, 0);
        check("idle_hold_rd", wb_rd, 5);

        // Contention from reset: units 0,1,3
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_instret", instret, 0);
        for (int u = 0; u < NU; u++)
            put(u, pack(44'(u), 2'(u), 32'(u * 4), 4'h1, 1'b1, 6'(10 + u), 128'(u), 1'b1, 1'b1));
        in_valid = 4'b1011;
        #1;
        check("cont_ready0", in_ready, 4'b0001);
        step();
        check("cont_rd0", wb_rd, 10);
        in_valid = 4'b1010;
        #1;
        check("cont_ready1", in_ready, 4'b0010);
        step();
        check("cont_rd1", wb_rd, 11);
        in_valid = 4'b1000;
        #1;
        check("cont_ready3", in_ready, 4'b1000);
        step();
        check("cont_rd3", wb_rd, 13);
        check("cont_instret", instret, 3);
        in_valid = 4'b1001;
        #1;
        check("cont_ptr_back0", in_ready, 4'b0001);

        // Move pointer to 1 with a single packet from unit 0
        put(0, pack(44'h20, 2'd0, 32'h20, 4'h3, 1'b1, 6'd20, 128'h20, 1'b1, 1'b1));
        in_valid = 4'b0001;
        step();
        check("prep_instret", instret, 4);

        // Lock on unit 1 (3-packet instruction), unit 0 waiting throughout
        commits = 0;
        put(0, pack(44'h22, 2'd2, 32'h22, 4'h1, 1'b1, 6'd22, 128'h22, 1'b1, 1'b1));
        put(1, pack(44'h21, 2'd1, 32'h21, 4'h2, 1'b1, 6'd21, 128'hA, 1'b1, 1'b0));
        in_valid = 4'b0011;
        #1;
        check("lock_ready_sop", in_ready, 4'b0010);
        step();
        if (commit_valid) commits++;
        check("lock_sop_rd", wb_rd, 21);
        check("lock_sop_eop", wb_eop, 0);
        put(1, pack(44'h21, 2'd1, 32'h21, 4'h2, 1'b1, 6'd21, 128'hB, 1'b0, 1'b0));
        #1;
        check("lock_ready_mid", in_ready, 4'b0010);
        step();
        if (commit_valid) commits++;
        check("lock_mid_data", wb_data, 128'hB);
        in_valid = 4'b0001;
        #1;
        check("lock_idle_ready", in_ready, 4'b0000);
        step();
        if (commit_valid) commits++;
        check("lock_idle_wb_valid", wb_valid, 0);
        put(1, pack(44'h21, 2'd1, 32'h21, 4'h2, 1'b1, 6'd21, 128'hC, 1'b0, 1'b1));
        in_valid = 4'b0011;
        #1;
        check("lock_ready_eop", in_ready, 4'b0010);
        step();
        if (commit_valid) commits++;
        check("lock_eop_commit", commit_valid, 1);
        check("lock_eop_wid", commit_wid, 1);
        check("lock_eop_instret", instret, 5);
        in_valid = 4'b0001;
        #1;
        check("lock_u0_ready", in_ready, 4'b0001);
        step();
        if (commit_valid) commits++;
        in_valid = '0;
        check("lock_u0_rd", wb_rd, 22);
        check("lock_u0_wid", commit_wid, 2);
        check("lock_instret", instret, 6);
        step();
        if (commit_valid) commits++;
        check("lock_commit_count", commits, 2);

        // Branch (wb=0) on unit 3
        put(3, pack(44'h33, 2'd3, 32'h33, 4'h8, 1'b0, 6'd7, 128'h33, 1'b1, 1'b1));
        in_valid = 4'b1000;
        #1;
        check("br_ready", in_ready, 4'b1000);
        step();
        in_valid = '0;
        check("br_wb_valid", wb_valid, 0);
        check("br_commit", commit_valid, 1);
        check("br_commit_wid", commit_wid, 3);
        check("br_instret", instret, 7);
        check("br_wb_rd", wb_rd, 7);

        // Reset while locked on unit 2
        put(2, pack(44'h40, 2'd1, 32'h40, 4'h1, 1'b1, 6'd40, 128'h40, 1'b1, 1'b0));
        in_valid = 4'b0100;
        step();
        put(2, pack(44'h41, 2'd1, 32'h41, 4'h1, 1'b1, 6'd41, 128'h41, 1'b0, 1'b0));
        put(0, pack(44'h30, 2'd2, 32'h30, 4'h1, 1'b1, 6'd30, 128'h30, 1'b1, 1'b1));
        in_valid = 4'b0101;
        #1;
        check("rl_locked_ready", in_ready, 4'b0100);
        reset = 1'b1;
        step();
        check("rl_wb_valid", wb_valid, 0);
        check("rl_commit", commit_valid, 0);
        check("rl_instret", instret, 0);
        check("rl_wb_rd", wb_rd, 0);
        check("rl_wb_wid", wb_wid, 0);
        reset = 1'b0;
        put(2, pack(44'h42, 2'd1, 32'h42, 4'h1, 1'b1, 6'd42, 128'h42, 1'b1, 1'b1));
        #1;
        check("rl_after_ready", in_ready, 4'b0001);
        step();
        in_valid = '0;
        check("rl_after_rd", wb_rd, 30);
        check("rl_after_instret", instret, 1);

`ifdef COMMIT_ARB_PERF_EN
        // Unit 3 waits 5 cycles behind a unit-1 lock
        reset = 1'b1;
        step();
        reset = 1'b0;
        put(1, pack(44'h50, 2'd1, 32'h50, 4'h1, 1'b1, 6'd50, 128'h50, 1'b1, 1'b0));
        put(3, pack(44'h53, 2'd3, 32'h53, 4'h1, 1'b1, 6'd53, 128'h53, 1'b1, 1'b1));
        in_valid = 4'b0010;
        step();
        put(1, pack(44'h50, 2'd1, 32'h50, 4'h1, 1'b1, 6'd50, 128'h51, 1'b0, 1'b0));
        in_valid = 4'b1010;
        repeat (4) step();
        put(1, pack(44'h50, 2'd1, 32'h50, 4'h1, 1'b1, 6'd50, 128'h52, 1'b0, 1'b1));
        step();
        in_valid = 4'b1000;
        step();
        in_valid = '0;
        check("perf_u3", perf_stalls[3*44 +: 44], 44'd5);
        check("perf_u1", perf_stalls[1*44 +: 44], 44'd0);
        check("perf_u3_wb_rd", wb_rd, 53);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
